// File: rtl/dmem_arbiter.sv
// Purpose: shares the LSU load/store port between m0 (core) and m1 (debug/loader), round-robin or m0-priority.
// Latency: req sampled in IDLE -> gnt the next cycle (ACCESS) -> rvalid the cycle after (RESP); one access per 3 cycles.
// Backpressure: a requester holds req and fields until its gnt; requests arriving in ACCESS/RESP wait for the next IDLE.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_bmask,
    input  logic [2:0]        m0_ld_sel,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_bmask,
    input  logic [2:0]        m1_ld_sel,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr_en,
    output logic [3:0]        mem_bmask,
    output logic [2:0]        mem_ld_sel,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // sel/last: 0 = m0, 1 = m1. last resets to 1 so m0 wins the first tie.
    logic              sel;
    logic              last;
    logic              take;
    logic              pick;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_bmask;
    logic [2:0]        lat_ld_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and arbitration decision; a winner is only chosen in IDLE.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                    if (m0_req && m1_req) begin
                        pick = RR_EN ? ~last : 1'b0;
                    end else begin
                        pick = m1_req;
                    end
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's fields, update the fairness pointer and capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= 1'b0;
            last       <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_bmask  <= '0;
            lat_ld_sel <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (take) begin
                sel        <= pick;
                lat_we     <= pick ? m1_we     : m0_we;
                lat_addr   <= pick ? m1_addr   : m0_addr;
                lat_wdata  <= pick ? m1_wdata  : m0_wdata;
                lat_bmask  <= pick ? m1_bmask  : m0_bmask;
                lat_ld_sel <= pick ? m1_ld_sel : m0_ld_sel;
            end
            if (state == ACCESS) begin
                last <= sel;
                // Only the selected requester's rdata register is written.
                if (sel) begin
                    m1_rdata <= mem_rdata;
                end else begin
                    m0_rdata <= mem_rdata;
                end
            end
        end
    end

    // The LSU always sees the latched request; writes are qualified to ACCESS only.
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign mem_bmask  = lat_bmask;
    assign mem_ld_sel = lat_ld_sel;
    assign mem_wr_en  = (state == ACCESS) && lat_we;

    assign m0_gnt    = (state == ACCESS) && !sel;
    assign m1_gnt    = (state == ACCESS) &&  sel;
    assign m0_rvalid = (state == RESP)   && !sel;
    assign m1_rvalid = (state == RESP)   &&  sel;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_bmask, m1_bmask;
    logic [2:0]    m0_ld_sel, m1_ld_sel;

    logic          rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_mem_wr_en, rr_busy;
    logic [31:0]   rr_m0_rdata, rr_m1_rdata, rr_mem_wdata, rr_mem_rdata;
    logic [AW-1:0] rr_mem_addr;
    logic [3:0]    rr_mem_bmask;
    logic [2:0]    rr_mem_ld_sel;

    logic          fx_m0_gnt, fx_m0_rvalid, fx_m1_gnt, fx_m1_rvalid, fx_mem_wr_en, fx_busy;
    logic [31:0]   fx_m0_rdata, fx_m1_rdata, fx_mem_wdata, fx_mem_rdata;
    logic [AW-1:0] fx_mem_addr;
    logic [3:0]    fx_mem_bmask;
    logic [2:0]    fx_mem_ld_sel;

    // Behavioural LSU: 256-word array, combinational read, byte-masked write.
    logic [31:0] tmem [0:255];
    assign rr_mem_rdata = tmem[rr_mem_addr[7:0]];
    assign fx_mem_rdata = tmem[fx_mem_addr[7:0]];
    always @(posedge clk) begin
        if (rr_mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (rr_mem_bmask[b]) tmem[rr_mem_addr[7:0]][8*b +: 8] <= rr_mem_wdata[8*b +: 8];
            end
        end
    end

    dmem_arbiter #(.ADDR_W(AW), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bmask(m0_bmask), .m0_ld_sel(m0_ld_sel),
        .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bmask(m1_bmask), .m1_ld_sel(m1_ld_sel),
        .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wr_en(rr_mem_wr_en),
        .mem_bmask(rr_mem_bmask), .mem_ld_sel(rr_mem_ld_sel), .mem_rdata(rr_mem_rdata),
        .busy(rr_busy)
    );

    dmem_arbiter #(.ADDR_W(AW), .RR_EN(1'b0)) u_fx (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bmask(m0_bmask), .m0_ld_sel(m0_ld_sel),
        .m0_gnt(fx_m0_gnt), .m0_rvalid(fx_m0_rvalid), .m0_rdata(fx_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bmask(m1_bmask), .m1_ld_sel(m1_ld_sel),
        .m1_gnt(fx_m1_gnt), .m1_rvalid(fx_m1_rvalid), .m1_rdata(fx_m1_rdata),
        .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_wr_en(fx_mem_wr_en),
        .mem_bmask(fx_mem_bmask), .mem_ld_sel(fx_mem_ld_sel), .mem_rdata(fx_mem_rdata),
        .busy(fx_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_bmask = '0; m0_ld_sel = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_bmask = '0; m1_ld_sel = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        flags = {rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid, rr_busy, rr_mem_wr_en};
        checks++;
        if (flags !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", flags); end
        checks++;
        if ({rr_mem_addr, rr_mem_wdata, rr_mem_bmask, rr_mem_ld_sel} !== '0) begin
            errors++; $display("FAIL reset_mem: addr %h wdata %h bmask %h ld %h expected all 0",
                               rr_mem_addr, rr_mem_wdata, rr_mem_bmask, rr_mem_ld_sel);
        end
        checks++;
        if ({rr_m0_rdata, rr_m1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0", rr_m0_rdata, rr_m1_rdata);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_load();
        tmem[8'h10] = 32'hDEADBEEF;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010; m0_ld_sel = 3'b010;
        @(negedge clk);
        checks++;
        if (rr_m0_gnt !== 1'b0 || rr_busy !== 1'b0) begin
            errors++; $display("FAIL load_idle: gnt %b busy %b expected 0 0", rr_m0_gnt, rr_busy);
        end
        @(negedge clk);
        checks++;
        if ({rr_m0_gnt, rr_m1_gnt, rr_mem_wr_en, rr_busy} !== 4'b1001) begin
            errors++; $display("FAIL load_gnt: got %b expected 1001", {rr_m0_gnt, rr_m1_gnt, rr_mem_wr_en, rr_busy});
        end
        checks++;
        if (rr_mem_addr !== 16'h0010 || rr_mem_ld_sel !== 3'b010) begin
            errors++; $display("FAIL load_mem: addr %h ld %h expected 0010 2", rr_mem_addr, rr_mem_ld_sel);
        end
        step();
        m0_req = 0;
        @(negedge clk);
        checks++;
        if ({rr_m0_rvalid, rr_m1_rvalid, rr_m1_gnt} !== 3'b100 || rr_m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_resp: rv %b%b rdata %h expected 1 0 DEADBEEF",
                               rr_m0_rvalid, rr_m1_rvalid, rr_m0_rdata);
        end
        checks++;
        if (rr_m1_rdata !== 32'h0) begin errors++; $display("FAIL load_m1_rdata: got %h expected 0", rr_m1_rdata); end
        @(negedge clk);
        checks++;
        if (rr_busy !== 1'b0) begin errors++; $display("FAIL load_done: busy %b expected 0", rr_busy); end
    endtask

    task automatic test_store_then_load();
        int wr_cnt = 0;
        step();
        m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 32'h12345678; m1_bmask = 4'hF;
        @(negedge clk); wr_cnt += rr_mem_wr_en;
        @(negedge clk); wr_cnt += rr_mem_wr_en;
        checks++;
        if (rr_m1_gnt !== 1'b1 || rr_mem_wdata !== 32'h12345678 || rr_mem_addr !== 16'h0020) begin
            errors++; $display("FAIL store_gnt: gnt %b wdata %h addr %h expected 1 12345678 0020",
                               rr_m1_gnt, rr_mem_wdata, rr_mem_addr);
        end
        step();
        m1_req = 0;
        @(negedge clk); wr_cnt += rr_mem_wr_en;
        checks++;
        if (rr_m1_rvalid !== 1'b1) begin errors++; $display("FAIL store_rvalid: got %b expected 1", rr_m1_rvalid); end
        @(negedge clk); wr_cnt += rr_mem_wr_en;
        checks++;
        if (wr_cnt != 1) begin errors++; $display("FAIL store_wr_cycles: got %0d expected 1", wr_cnt); end
        checks++;
        if (rr_m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL m0_rdata_hold: got %h expected DEADBEEF", rr_m0_rdata);
        end
        step();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0020; m0_ld_sel = 3'b010;
        @(negedge clk);
        @(negedge clk);
        step();
        m0_req = 0;
        @(negedge clk);
        checks++;
        if (rr_m0_rvalid !== 1'b1 || rr_m0_rdata !== 32'h12345678) begin
            errors++; $display("FAIL store_load_back: rv %b rdata %h expected 1 12345678", rr_m0_rvalid, rr_m0_rdata);
        end
        step();
    endtask

    task automatic test_rr_contention();
        int order[$];
        int when[$];
        int both = 0;
        do_reset();
        m0_req = 1; m0_addr = 16'h0004; m1_req = 1; m1_addr = 16'h0008;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rr_m0_gnt && rr_m1_gnt) both++;
            if (rr_m0_gnt) begin order.push_back(0); when.push_back(c); end
            if (rr_m1_gnt) begin order.push_back(1); when.push_back(c); end
        end
        checks++;
        if (both != 0) begin errors++; $display("FAIL rr_double_gnt: got %0d expected 0", both); end
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL rr_gnt_count: got %0d expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != (i % 2) || when[i] != 1 + 3 * i) begin
                    errors++; $display("FAIL rr_order[%0d]: got m%0d at %0d expected m%0d at %0d",
                                       i, order[i], when[i], i % 2, 1 + 3 * i);
                end
            end
        end
        step();
        clear_reqs();
    endtask

    task automatic test_fixed_contention();
        int g0 = 0;
        int g1 = 0;
        bit seen = 0;
        do_reset();
        m0_req = 1; m1_req = 1; m1_addr = 16'h000C;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g0 += fx_m0_gnt;
            g1 += fx_m1_gnt;
        end
        checks++;
        if (g0 != 4 || g1 != 0) begin errors++; $display("FAIL fx_gnts: got m0=%0d m1=%0d expected 4 0", g0, g1); end
        step();
        m0_req = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (fx_m1_gnt) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fx_m1_after_drop: got no gnt expected m1_gnt"); end
        step();
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        bit seen0 = 0;
        bit seen1 = 0;
        do_reset();
        m1_req = 1; m1_addr = 16'h0030; m1_ld_sel = 3'b010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rr_m1_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b expected 1", rr_m1_gnt); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_busy, rr_m1_rvalid, rr_m1_gnt, rr_mem_wr_en} !== 4'b0 ||
            {rr_mem_addr, rr_mem_wdata, rr_mem_bmask, rr_mem_ld_sel} !== '0) begin
            errors++; $display("FAIL rstmid_state: busy %b rv %b addr %h ld %h expected all 0",
                               rr_busy, rr_m1_rvalid, rr_mem_addr, rr_mem_ld_sel);
        end
        step();
        rst = 1'b0;
        m0_req = 1; m0_addr = 16'h0034;
        for (int c = 0; c < 4 && !seen0 && !seen1; c++) begin
            @(negedge clk);
            seen0 = rr_m0_gnt;
            seen1 = rr_m1_gnt;
        end
        checks++;
        if (!seen0 || seen1) begin errors++; $display("FAIL rstmid_first: got m0=%b m1=%b expected 1 0", seen0, seen1); end
        step();
        clear_reqs();
    endtask

    task automatic test_bmask();
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0040; m0_wdata = 32'h00AB0000; m0_bmask = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rr_mem_bmask !== 4'b0100 || rr_mem_wdata !== 32'h00AB0000 || rr_mem_wr_en !== 1'b1) begin
            errors++; $display("FAIL bmask_access: bmask %b wdata %h we %b expected 0100 00AB0000 1",
                               rr_mem_bmask, rr_mem_wdata, rr_mem_wr_en);
        end
        step();
        m0_req = 0;
        @(negedge clk);
        checks++;
        if (rr_m0_rvalid !== 1'b1 || rr_mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL bmask_resp: rv %b we %b expected 1 0", rr_m0_rvalid, rr_mem_wr_en);
        end
        step();
        clear_reqs();
    endtask

    task automatic new_req(input int i);
        if (i == 0) begin
            m0_req = 1; m0_we = $urandom_range(0, 1); m0_addr = AW'($urandom);
            m0_wdata = $urandom; m0_bmask = 4'($urandom); m0_ld_sel = 3'($urandom_range(0, 4));
        end else begin
            m1_req = 1; m1_we = $urandom_range(0, 1); m1_addr = AW'($urandom);
            m1_wdata = $urandom; m1_bmask = 4'($urandom); m1_ld_sel = 3'($urandom_range(0, 4));
        end
    endtask

    // Transaction-level model: a 3-cycle occupancy window and a "last winner" pointer.
    task automatic test_random();
        int phase = 0;
        int win = 0;
        int mlast = 1;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata, e_rd;
        logic [3:0]    e_bmask;
        logic [2:0]    e_ld;
        logic [5:0]    got, exp;
        int grants = 0;
        do_reset();
        e_we = 0; e_addr = '0; e_wdata = '0; e_bmask = '0; e_ld = '0; e_rd = '0;
        for (int c = 0; c < 400; c++) begin
            if (phase == 2) begin
                if (win == 0) m0_req = 0; else m1_req = 0;
            end
            if (!m0_req && $urandom_range(0, 2) == 0) new_req(0);
            if (!m1_req && $urandom_range(0, 2) == 0) new_req(1);
            @(negedge clk);
            exp = {phase == 1 && win == 0, phase == 1 && win == 1, phase == 2 && win == 0,
                   phase == 2 && win == 1, phase != 0, phase == 1 && e_we};
            got = {rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid, rr_busy, rr_mem_wr_en};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", c, got, exp); end
            if (phase == 1) begin
                grants++;
                checks++;
                if (rr_mem_addr !== e_addr || rr_mem_wdata !== e_wdata ||
                    rr_mem_bmask !== e_bmask || rr_mem_ld_sel !== e_ld) begin
                    errors++; $display("FAIL rand_mem[%0d]: got %h %h %h %h expected %h %h %h %h", c,
                                       rr_mem_addr, rr_mem_wdata, rr_mem_bmask, rr_mem_ld_sel,
                                       e_addr, e_wdata, e_bmask, e_ld);
                end
                e_rd = tmem[e_addr[7:0]];
            end
            if (phase == 2 && !e_we) begin
                checks++;
                if ((win == 0 ? rr_m0_rdata : rr_m1_rdata) !== e_rd) begin
                    errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c,
                                       win == 0 ? rr_m0_rdata : rr_m1_rdata, e_rd);
                end
            end
            @(posedge clk);
            if (phase == 0) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) win = (mlast == 1) ? 0 : 1;
                    else win = m1_req ? 1 : 0;
                    e_we    = win ? m1_we : m0_we;
                    e_addr  = win ? m1_addr : m0_addr;
                    e_wdata = win ? m1_wdata : m0_wdata;
                    e_bmask = win ? m1_bmask : m0_bmask;
                    e_ld    = win ? m1_ld_sel : m0_ld_sel;
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
                mlast = win;
            end else begin
                phase = 0;
            end
            #1;
        end
        checks++;
        if (grants < 50) begin errors++; $display("FAIL rand_activity: got %0d grants expected >= 50", grants); end
        clear_reqs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = $urandom;
        clear_reqs();
        rst = 1'b1;
        test_reset();
        test_single_load();
        test_store_then_load();
        test_rr_contention();
        test_fixed_contention();
        test_reset_mid();
        test_bmask();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
